vta_axi_mem_bridge: RTL

- AXI4 slave-side bridge between the VTA shell's memory master and the simulation memory DPI stage.
- Converts single outstanding AXI read/write bursts into the DPI request/write/read-beat protocol.
- Sits directly upstream of the DPI memory stage: drives its req/wr inputs and consumes its registered rd_valid/rd_bits.
- One transaction in flight at a time.

---
 rtl/vta_mem_pkg.sv | 19 +
 rtl/vta_axi_mem_bridge.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vta_mem_pkg.sv
// Shared types and encodings for the VTA AXI-to-DPI memory bridge.
package vta_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_WR_RESP = 3'd5
    } state_t;

    localparam logic MEM_OP_RD = 1'b0;
    localparam logic MEM_OP_WR = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/vta_axi_mem_bridge.sv
// AXI4 slave bridge turning single outstanding bursts into DPI req/wr/rd-beat traffic.
// Optional round-robin AR/AW arbitration in IDLE when VTA_MEM_BRIDGE_RR_EN is defined.
module vta_axi_mem_bridge
    import vta_mem_pkg::*;
#(
    parameter int unsigned LEN_BITS  = 8,
    parameter int unsigned ADDR_BITS = 64,
    parameter int unsigned DATA_BITS = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 axi_aw_valid,
    output logic                 axi_aw_ready,
    input  logic [ADDR_BITS-1:0] axi_aw_addr,
    input  logic [LEN_BITS-1:0]  axi_aw_len,
    input  logic                 axi_w_valid,
    output logic                 axi_w_ready,
    input  logic [DATA_BITS-1:0] axi_w_data,
    input  logic                 axi_w_last,
    output logic                 axi_b_valid,
    input  logic                 axi_b_ready,
    output logic [1:0]           axi_b_resp,
    input  logic                 axi_ar_valid,
    output logic                 axi_ar_ready,
    input  logic [ADDR_BITS-1:0] axi_ar_addr,
    input  logic [LEN_BITS-1:0]  axi_ar_len,
    output logic                 axi_r_valid,
    input  logic                 axi_r_ready,
    output logic [DATA_BITS-1:0] axi_r_data,
    output logic [1:0]           axi_r_resp,
    output logic                 axi_r_last,
    output logic                 dpi_req_valid,
    output logic                 dpi_req_opcode,
    output logic [LEN_BITS-1:0]  dpi_req_len,
    output logic [ADDR_BITS-1:0] dpi_req_addr,
    output logic                 dpi_wr_valid,
    output logic [DATA_BITS-1:0] dpi_wr_bits,
    input  logic                 dpi_rd_valid,
    input  logic [DATA_BITS-1:0] dpi_rd_bits,
    output logic                 dpi_rd_ready
);

    state_t                state, state_nxt;
    logic                  armed;
    logic                  live;
    logic                  wr_first;
    logic                  rd_go, wr_go, rd_fire, wr_fire;
    logic                  cnt_zero;
    logic [LEN_BITS-1:0]   cnt;
    logic [LEN_BITS-1:0]   len_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic                  op_q;
    logic                  err_q;

    // Handshake outputs stay quiet while in reset and for one cycle afterwards.
    assign live     = armed && !reset;
    assign cnt_zero = (cnt == '0);

`ifdef VTA_MEM_BRIDGE_RR_EN
    logic wr_first_q;

    // Priority flips to the other channel after every grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_first_q <= 1'b0;
        end else if (rd_go) begin
            wr_first_q <= 1'b1;
        end else if (wr_go) begin
            wr_first_q <= 1'b0;
        end
    end

    assign wr_first = wr_first_q;
`else
    assign wr_first = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        axi_ar_ready   = 1'b0;
        axi_aw_ready   = 1'b0;
        axi_w_ready    = 1'b0;
        axi_b_valid    = 1'b0;
        axi_b_resp     = err_q ? RESP_SLVERR : RESP_OKAY;
        axi_r_valid    = 1'b0;
        axi_r_data     = dpi_rd_bits;
        axi_r_resp     = RESP_OKAY;
        axi_r_last     = 1'b0;
        dpi_req_valid  = 1'b0;
        dpi_req_opcode = op_q;
        dpi_req_len    = len_q;
        dpi_req_addr   = addr_q;
        dpi_wr_valid   = 1'b0;
        dpi_wr_bits    = axi_w_data;
        dpi_rd_ready   = 1'b0;
        rd_go          = 1'b0;
        wr_go          = 1'b0;
        rd_fire        = 1'b0;
        wr_fire        = 1'b0;
        if (live) begin
            case (state)
                ST_IDLE: begin
                    axi_ar_ready = !(wr_first && axi_aw_valid);
                    axi_aw_ready = !(!wr_first && axi_ar_valid);
                    rd_go        = axi_ar_valid && axi_ar_ready;
                    wr_go        = axi_aw_valid && axi_aw_ready;
                    if (rd_go) begin
                        state_nxt = ST_RD_REQ;
                    end else if (wr_go) begin
                        state_nxt = ST_WR_REQ;
                    end
                end
                ST_RD_REQ: begin
                    dpi_req_valid = 1'b1;
                    state_nxt     = ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    axi_r_valid  = dpi_rd_valid;
                    axi_r_last   = cnt_zero;
                    dpi_rd_ready = axi_r_ready;
                    rd_fire      = dpi_rd_valid && axi_r_ready;
                    if (rd_fire && cnt_zero) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    dpi_req_valid = 1'b1;
                    state_nxt     = ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    axi_w_ready  = 1'b1;
                    dpi_wr_valid = axi_w_valid;
                    wr_fire      = axi_w_valid;
                    if (wr_fire && cnt_zero) begin
                        state_nxt = ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    axi_b_valid = 1'b1;
                    if (axi_b_ready) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Request capture, beat counter and write-error latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            armed  <= 1'b0;
            cnt    <= '0;
            len_q  <= '0;
            addr_q <= '0;
            op_q   <= MEM_OP_RD;
            err_q  <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (rd_go) begin
                addr_q <= axi_ar_addr;
                len_q  <= axi_ar_len;
                op_q   <= MEM_OP_RD;
            end else if (wr_go) begin
                addr_q <= axi_aw_addr;
                len_q  <= axi_aw_len;
                op_q   <= MEM_OP_WR;
            end
            if (state == ST_RD_REQ || state == ST_WR_REQ) begin
                cnt <= len_q;
            end else if ((rd_fire || wr_fire) && !cnt_zero) begin
                cnt <= cnt - LEN_BITS'(1);
            end
            // The beat count decides the burst end; a misplaced w_last only flags an error.
            if (wr_fire && (axi_w_last != cnt_zero)) begin
                err_q <= 1'b1;
            end else if (axi_b_valid && axi_b_ready) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule
